implication_responder: RTL and testbench

Responder end of the single-bit req/ack handshake used by the implication examples. It produces the consequent (`ack`) for every antecedent (`req`) after a fixed latency. Acknowledgements are deferred in order while the consumer asserts `hold`. It gives the `req |-> ##LATENCY ack` family of properties a real design to bind against, with backlog, stall and overflow behaviour to check.

---
 rtl/implication_pkg.sv | 8 +
 rtl/req_delay_line.sv | 18 +
 rtl/implication_responder.sv | 46 ++++
 tb/tb_implication_responder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/implication_pkg.sv
// implication_pkg: limits and width helper shared by the implication responder and its bind files.
package implication_pkg;
    localparam int LATENCY_MAX = 15;
    localparam int PENDING_MAX = 255;
    function automatic int pending_w(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction
endpackage

// File: rtl/req_delay_line.sv
// req_delay_line: DEPTH-deep request shift register with matured output and in-flight flag.
module req_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic matured,
    output logic any_in_flight
);
    logic [DEPTH-1:0] sr;
    logic [DEPTH:0]   nxt;
    assign nxt = {sr, req};
    always_ff @(posedge clk)
        sr <= rst ? '0 : nxt[DEPTH-1:0];
    assign matured       = sr[DEPTH-1];
    assign any_in_flight = |sr;
endmodule

// File: rtl/implication_responder.sv
// implication_responder: acks each req after LATENCY cycles, deferring in order while hold is high.
module implication_responder
    import implication_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int MAX_PENDING = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req,
    input  logic                                hold,
    output logic                                ack,
    output logic                                busy,
    output logic [pending_w(MAX_PENDING)-1:0]   pending,
    output logic                                overflow
);
    localparam int PW = pending_w(MAX_PENDING);
    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("LATENCY out of range 1..%0d", LATENCY_MAX);
    end
    if (MAX_PENDING < 1 || MAX_PENDING > PENDING_MAX) begin : g_bad_pending
        $error("MAX_PENDING out of range 1..%0d", PENDING_MAX);
    end
    logic matured, in_flight, full;
    req_delay_line #(.DEPTH(LATENCY)) u_dl (
        .clk(clk),
        .rst(rst),
        .req(req),
        .matured(matured),
        .any_in_flight(in_flight)
    );
    // backlog drains first, so a matured request only bypasses it when the backlog is empty
    assign ack  = !rst && !hold && (pending != '0 || matured);
    assign full = pending == PW'(MAX_PENDING);
    assign busy = in_flight || pending != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (matured && !ack && full) begin
            overflow <= 1'b1;
        end else begin
            pending <= pending + PW'(matured) - PW'(ack);
        end
    end
endmodule

// File: tb/tb_implication_responder.sv
// tb_implication_responder: directed stimulus with an ack-cycle scoreboard drained by a monitor.
module tb_implication_responder;
    logic clk = 0, rst = 1, req = 0, hold = 0;
    logic ack, busy, overflow;
    logic [1:0] pending;
    int cyc = 0, checks = 0, errors = 0, s;
    int exp_q[$];

    implication_responder #(.LATENCY(2), .MAX_PENDING(2)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .hold(hold),
        .ack(ack),
        .busy(busy),
        .pending(pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic go(input logic r, input logic h, input logic rs);
        @(posedge clk);
        #1;
        req = r;
        hold = h;
        rst = rs;
        @(negedge clk);
    endtask

    // every ack must match the oldest expected ack cycle
    always @(negedge clk)
        if (ack !== 1'b0) begin
            if (exp_q.size() == 0) chk("unexpected_ack", cyc, -1);
            else chk("ack_cycle", cyc, exp_q.pop_front());
        end

    initial begin
        go(1, 0, 1);
        go(0, 0, 1);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
        go(0, 0, 0);
        chk("rst_req_ignored", busy, 0);

        go(1, 0, 0);
        exp_q.push_back(cyc + 2);
        go(0, 0, 0);
        chk("single_busy1", busy, 1);
        go(0, 0, 0);
        chk("single_busy2", busy, 1);
        chk("single_pending", pending, 0);
        go(0, 0, 0);
        chk("single_busy_fall", busy, 0);

        repeat (4) begin
            go(1, 0, 0);
            exp_q.push_back(cyc + 2);
        end
        repeat (3) begin
            go(0, 0, 0);
            chk("b2b_pending", pending, 0);
        end
        chk("b2b_busy_fall", busy, 0);

        go(1, 1, 0);
        s = cyc;
        exp_q.push_back(s + 5);
        go(1, 1, 0);
        exp_q.push_back(s + 6);
        go(0, 1, 0);
        chk("stall_pend0", pending, 0);
        go(0, 1, 0);
        chk("stall_pend1", pending, 1);
        go(0, 1, 0);
        chk("stall_pend2", pending, 2);
        go(0, 0, 0);
        chk("drain_pend2", pending, 2);
        chk("drain_busy", busy, 1);
        go(0, 0, 0);
        chk("drain_pend1", pending, 1);
        go(0, 0, 0);
        chk("drain_pend0", pending, 0);
        chk("drain_busy_fall", busy, 0);

        go(1, 1, 0);
        s = cyc;
        exp_q.push_back(s + 7);
        go(1, 1, 0);
        exp_q.push_back(s + 8);
        go(1, 1, 0);
        go(1, 1, 0);
        chk("ovf_pend1", pending, 1);
        go(0, 1, 0);
        chk("ovf_pend2", pending, 2);
        chk("ovf_not_yet", overflow, 0);
        go(0, 1, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_pend_sat", pending, 2);
        go(0, 1, 0);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_pend_sat2", pending, 2);
        go(0, 0, 0);
        go(0, 0, 0);
        go(0, 0, 0);
        chk("ovf_drained", pending, 0);
        chk("ovf_sticky_after", overflow, 1);
        chk("ovf_busy_fall", busy, 0);

        go(1, 0, 0);
        go(1, 0, 0);
        go(0, 0, 1);
        chk("midrst_ack", ack, 0);
        go(0, 0, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_overflow", overflow, 0);
        repeat (4) go(0, 0, 0);

        go(1, 0, 0);
        exp_q.push_back(cyc + 2);
        repeat (3) go(0, 0, 0);
        chk("missing_acks", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
